// File: rtl/cache_tag_array_nway_pkg.sv
// Shared types and constants for the N-way cache tag store.
package cache_tag_pkg;

    localparam int DEF_TAG_WIDTH = 23;
    localparam int DEF_SET_BITS  = 4;
    localparam int DEF_WAYS      = 4;
    localparam int SETS          = 1 << DEF_SET_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } tag_fsm_e;

    typedef logic [DEF_TAG_WIDTH-1:0] tag_t;
    typedef logic [DEF_SET_BITS-1:0]  set_idx_t;

    // A way index needs at least one bit even for a direct-mapped store.
    function automatic int way_idx_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int WAY_IDX_BITS = way_idx_bits(DEF_WAYS);

endpackage

// File: rtl/cache_tag_array_nway_tag_way_bank.sv
// One way of the tag store: tag storage, valid bits and the registered per-way compare.
module tag_way_bank #(
    parameter int TAG_WIDTH = 23,
    parameter int SET_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [SET_BITS-1:0]  addr,
    input  logic [TAG_WIDTH-1:0] din,
    input  logic                 vin,
    input  logic [TAG_WIDTH-1:0] cmp_tag,
    input  logic                 clr_en,
    input  logic [SET_BITS-1:0]  clr_addr,
    output logic [TAG_WIDTH-1:0] dout,
    output logic                 vout,
    output logic                 hit
);

    localparam int SETS = 1 << SET_BITS;

    logic [TAG_WIDTH-1:0] tag_q [SETS];
    logic [TAG_WIDTH-1:0] tag_d [SETS];
    logic [SETS-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0] dout_q, dout_d;
    logic                 vout_q, vout_d;
    logic                 hit_q, hit_d;

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        if (wr_en) begin
            tag_d[addr]   = din;
            valid_d[addr] = vin;
        end
        if (clr_en) begin
            valid_d[clr_addr] = 1'b0;
        end
        dout_d = dout_q;
        vout_d = vout_q;
        hit_d  = hit_q;
        // Outputs reflect the set after this cycle's write (write-first).
        if (rd_en) begin
            dout_d = tag_d[addr];
            vout_d = valid_d[addr];
            hit_d  = valid_d[addr] && (tag_d[addr] == cmp_tag);
        end
    end

    always_ff @(posedge clk) begin
        tag_q   <= tag_d;
        valid_q <= valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            vout_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vout_q <= vout_d;
            hit_q  <= hit_d;
        end
    end

    assign dout = dout_q;
    assign vout = vout_q;
    assign hit  = hit_q;

endmodule

// File: rtl/cache_tag_array_nway.sv
// N-way set-associative tag store with per-way write mask, hit detection and flash invalidate.
module cache_tag_array_nway
    import cache_tag_pkg::*;
#(
    parameter int TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int SET_BITS  = DEF_SET_BITS,
    parameter int WAYS      = DEF_WAYS
) (
    input  logic                      clk0,
    input  logic                      rst0_n,
    input  logic                      csb0,
    input  logic                      web0,
    input  logic [WAYS-1:0]           wmask0,
    input  logic [SET_BITS-1:0]       addr0,
    input  logic [TAG_WIDTH-1:0]      din0,
    input  logic                      vin0,
    input  logic [TAG_WIDTH-1:0]      cmp_tag0,
    input  logic                      inv_req0,
    output logic                      busy0,
    output logic [WAYS*TAG_WIDTH-1:0] dout0,
    output logic [WAYS-1:0]           vout0,
    output logic [WAYS-1:0]           hit_vec0,
    output logic                      hit0,
    output logic                      multi_hit0
);

    localparam int                  N_IDX    = way_idx_bits(WAYS);
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'((1 << SET_BITS) - 1);

    tag_fsm_e            state_q, state_d;
    logic [SET_BITS-1:0] cnt_q, cnt_d;
    logic                clr_en;
    logic                accept;
    logic [WAYS-1:0]     way_we;
    logic [N_IDX:0]      hit_cnt;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Invalidate requests arriving during CLEAR are ignored rather than restarting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (inv_req0) state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_SET) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy0  = (state_q == CLEAR);
        clr_en = (state_q == CLEAR);
    end

    assign accept = !csb0 && !busy0;
    assign way_we = (accept && !web0) ? wmask0 : '0;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        tag_way_bank #(
            .TAG_WIDTH(TAG_WIDTH),
            .SET_BITS (SET_BITS)
        ) u_bank (
            .clk     (clk0),
            .rst_n   (rst0_n),
            .rd_en   (accept),
            .wr_en   (way_we[w]),
            .addr    (addr0),
            .din     (din0),
            .vin     (vin0),
            .cmp_tag (cmp_tag0),
            .clr_en  (clr_en),
            .clr_addr(cnt_q),
            .dout    (dout0[w*TAG_WIDTH +: TAG_WIDTH]),
            .vout    (vout0[w]),
            .hit     (hit_vec0[w])
        );
    end

    always_comb begin
        hit_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_cnt = hit_cnt + {{N_IDX{1'b0}}, hit_vec0[w]};
        end
    end

    assign hit0       = |hit_vec0;
    assign multi_hit0 = (hit_cnt > 1);

endmodule

// File: tb/tb_cache_tag_array_nway.sv
// Bench for cache_tag_array_nway: directed scenarios plus random traffic against a set/way model.
module tb_cache_tag_array_nway;
    import cache_tag_pkg::*;

    localparam int TW = 23;
    localparam int NW = 4;
    localparam int NS = 16;

    logic            clk0 = 1'b0;
    logic            rst0_n = 1'b0;
    logic            csb0 = 1'b1;
    logic            web0 = 1'b1;
    logic [NW-1:0]   wmask0 = '0;
    logic [3:0]      addr0 = '0;
    tag_t            din0 = '0;
    logic            vin0 = 1'b0;
    tag_t            cmp_tag0 = '0;
    logic            inv_req0 = 1'b0;
    logic            busy0;
    logic [NW*TW-1:0] dout0;
    logic [NW-1:0]   vout0;
    logic [NW-1:0]   hit_vec0;
    logic            hit0;
    logic            multi_hit0;

    int n_vec = 0;
    int n_err = 0;

    cache_tag_array_nway dut (
        .clk0(clk0), .rst0_n(rst0_n), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .vin0(vin0), .cmp_tag0(cmp_tag0), .inv_req0(inv_req0),
        .busy0(busy0), .dout0(dout0), .vout0(vout0), .hit_vec0(hit_vec0), .hit0(hit0),
        .multi_hit0(multi_hit0)
    );

    always #5 clk0 = ~clk0;

    // ---------------- behavioural model ----------------
    tag_t        tag_m   [NS][NW];
    logic        val_m   [NS][NW];
    logic        known_m [NS][NW];
    int          clr_left = NS;
    tag_t        exp_tag [NW];
    logic        exp_known [NW];
    logic [NW-1:0] exp_v = '0;
    logic [NW-1:0] exp_hit = '0;

    task automatic model_reset();
        clr_left = NS;
        exp_v = '0;
        exp_hit = '0;
        for (int w = 0; w < NW; w++) begin
            exp_tag[w] = '0;
            exp_known[w] = 1'b1;
        end
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) val_m[s][w] = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) known_m[s][w] = 1'b0;
        model_reset();
    end

    always @(negedge rst0_n) model_reset();

    always @(posedge clk0) begin
        if (rst0_n) begin
            if (clr_left > 0) begin
                clr_left = clr_left - 1;
            end else begin
                if (!csb0) begin
                    if (!web0) begin
                        for (int w = 0; w < NW; w++) begin
                            if (wmask0[w]) begin
                                tag_m[addr0][w]   = din0;
                                val_m[addr0][w]   = vin0;
                                known_m[addr0][w] = 1'b1;
                            end
                        end
                    end
                    for (int w = 0; w < NW; w++) begin
                        exp_tag[w]   = tag_m[addr0][w];
                        exp_known[w] = known_m[addr0][w];
                        exp_v[w]     = val_m[addr0][w];
                        exp_hit[w]   = val_m[addr0][w] && (tag_m[addr0][w] == cmp_tag0);
                    end
                end
                if (inv_req0) begin
                    clr_left = NS;
                    for (int s = 0; s < NS; s++)
                        for (int w = 0; w < NW; w++) val_m[s][w] = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string name, input logic [NW*TW-1:0] act, input logic [NW*TW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    always @(negedge clk0) begin
        logic [NW*TW-1:0] d_act, d_exp;
        d_act = '0;
        d_exp = '0;
        for (int w = 0; w < NW; w++) begin
            if (exp_known[w]) begin
                d_act[w*TW +: TW] = dout0[w*TW +: TW];
                d_exp[w*TW +: TW] = exp_tag[w];
            end
        end
        chk("busy", (NW*TW)'(busy0), (NW*TW)'(clr_left > 0));
        chk("dout", d_act, d_exp);
        chk("vout", (NW*TW)'(vout0), (NW*TW)'(exp_v));
        chk("hit_vec", (NW*TW)'(hit_vec0), (NW*TW)'(exp_hit));
        chk("hit", (NW*TW)'(hit0), (NW*TW)'(|exp_hit));
        chk("multi_hit", (NW*TW)'(multi_hit0), (NW*TW)'($countones(exp_hit) > 1));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk0);
        #2;
        csb0 = 1'b1;
        web0 = 1'b1;
        inv_req0 = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [NW-1:0] m, input tag_t t,
                            input logic v, input tag_t c, input logic inv);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; wmask0 = m; din0 = t; vin0 = v;
        cmp_tag0 = c; inv_req0 = inv;
        step();
    endtask

    task automatic do_read(input logic [3:0] a, input tag_t c);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a; cmp_tag0 = c;
        wmask0 = NW'($urandom_range(0, 15)); din0 = TW'($urandom);
        step();
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy0 && n < 100) begin
            do_read(4'($urandom_range(0, 15)), TW'($urandom));
            n++;
        end
        chk(name, (NW*TW)'(n), (NW*TW)'(NS));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) step();
        chk("reset_outputs", (NW*TW)'({dout0, vout0, hit_vec0, hit0, multi_hit0}), '0);
        rst0_n = 1'b1;
        count_busy("busy_after_reset");

        do_read(4'd5, TW'($urandom));
        chk("set5_vout", (NW*TW)'(vout0), '0);
        chk("set5_hit", (NW*TW)'(hit0), '0);

        do_write(4'd3, 4'b0100, 23'h1ABCDE, 1'b1, '0, 1'b0);
        do_read(4'd3, 23'h1ABCDE);
        chk("set3_hit_vec", (NW*TW)'(hit_vec0), (NW*TW)'(4'b0100));
        chk("set3_way2", (NW*TW)'(dout0[2*TW +: TW]), (NW*TW)'(23'h1ABCDE));
        chk("set3_multi", (NW*TW)'({hit0, multi_hit0}), (NW*TW)'(2'b10));

        do_write(4'd7, 4'b0011, 23'h000042, 1'b1, 23'h000042, 1'b0);
        do_read(4'd7, 23'h000042);
        chk("set7_hit_vec", (NW*TW)'(hit_vec0), (NW*TW)'(4'b0011));
        chk("set7_multi", (NW*TW)'(multi_hit0), (NW*TW)'(1'b1));

        do_write(4'd3, 4'b1011, 23'h00ABCD, 1'b1, '0, 1'b0);
        do_write(4'd3, 4'b0100, 23'h1ABCDE, 1'b0, 23'h1ABCDE, 1'b0);
        do_read(4'd3, 23'h1ABCDE);
        chk("inv3_vout", (NW*TW)'(vout0), (NW*TW)'(4'b1011));
        chk("inv3_hit", (NW*TW)'(hit0), '0);
        chk("inv3_way0", (NW*TW)'(dout0[0 +: TW]), (NW*TW)'(23'h00ABCD));

        do_write(4'd9, 4'b1111, 23'h000055, 1'b1, 23'h000055, 1'b1);
        chk("set9_write_vout", (NW*TW)'({busy0, vout0}), (NW*TW)'(5'b11111));
        count_busy("busy_after_inv");
        do_read(4'd9, 23'h000055);
        chk("set9_cleared", (NW*TW)'({vout0, hit0}), '0);

        do_write(4'd1, 4'b0001, 23'h000011, 1'b1, '0, 1'b1);
        repeat (8) step();
        rst0_n = 1'b0;
        #1;
        chk("midclear_reset", (NW*TW)'({dout0, vout0, hit_vec0, hit0, multi_hit0}), '0);
        chk("midclear_busy", (NW*TW)'(busy0), (NW*TW)'(1'b1));
        repeat (2) step();
        rst0_n = 1'b1;
        count_busy("busy_after_midclear");

        for (int i = 0; i < 600; i++) begin
            csb0 = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            web0 = $urandom_range(0, 1) != 0;
            addr0 = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3));
            wmask0 = NW'($urandom_range(0, 15));
            din0 = ($urandom_range(0, 1) != 0) ? TW'($urandom_range(0, 3)) : TW'($urandom);
            vin0 = $urandom_range(0, 3) != 0;
            cmp_tag0 = TW'($urandom_range(0, 3));
            inv_req0 = ($urandom_range(0, 60) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
